// File: rtl/str_match.sv
// str_match: assembles received bytes into words and decodes start/stop/hitsz commands
module str_match #(
  parameter int TIMEOUT = 150000,
  parameter int MAX_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_vld,
  input  logic [7:0] rx_data,
  output logic       cmd_vld,
  output logic [1:0] cmd_code,
  output logic       run
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int LW = $clog2(MAX_LEN + 2);
  typedef enum logic [1:0] {IDLE, RECV, EVAL} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] len_q, len_d, len_base;
  logic [7:0] buf_q [MAX_LEN];
  logic [7:0] buf_d [MAX_LEN];
  logic cmd_vld_d, run_d;
  logic [1:0] cmd_code_d, code;
  logic term, acc, expire;
  logic [39:0] w5;
  assign term   = (rx_data == 8'h0D) || (rx_data == 8'h0A);
  assign acc    = rx_vld && !term;
  assign expire = (cnt_q == CW'(TIMEOUT - 1)) && !rx_vld;
  assign w5     = {buf_q[0], buf_q[1], buf_q[2], buf_q[3], buf_q[4]};
  // classify the buffered word against the three keywords
  always_comb begin
    code = (len_q == LW'(5) && w5 == "start") ? 2'd1 :
           (len_q == LW'(4) && w5[39:8] == "stop") ? 2'd2 :
           (len_q == LW'(5) && w5 == "hitsz") ? 2'd3 : 2'd0;
  end
  // next state: bytes always reopen a word, even during evaluation
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = acc ? RECV : IDLE;
      RECV:    state_d = acc ? RECV : ((rx_vld && term) || expire) ? EVAL : RECV;
      default: state_d = acc ? RECV : IDLE;
    endcase
  end
  // word buffer, length and idle counter; evaluation clears the word before a new byte lands
  always_comb begin
    len_base = (state_q == EVAL) ? '0 : len_q;
    for (int i = 0; i < MAX_LEN; i++) buf_d[i] = (state_q == EVAL) ? 8'h00 : buf_q[i];
    for (int i = 0; i < MAX_LEN; i++) if (acc && len_base == LW'(i)) buf_d[i] = rx_data;
    len_d = !acc ? len_base : (len_base == LW'(MAX_LEN + 1)) ? len_base : len_base + LW'(1);
    cnt_d = (state_q == RECV && !rx_vld) ? cnt_q + CW'(1) : '0;
  end
  // registered outputs update only on the evaluation cycle
  always_comb begin
    cmd_vld_d  = (state_q == EVAL);
    cmd_code_d = (state_q == EVAL) ? code : cmd_code;
    run_d      = (state_q == EVAL && code == 2'd1) ? 1'b1 :
                 (state_q == EVAL && code == 2'd2) ? 1'b0 : run;
  end
  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= buf_d[i];
    end
  end
  // output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_vld  <= 1'b0;
      cmd_code <= 2'd0;
      run      <= 1'b0;
    end else begin
      cmd_vld  <= cmd_vld_d;
      cmd_code <= cmd_code_d;
      run      <= run_d;
    end
  end
endmodule

// File: tb/tb_str_match.sv
// tb_str_match: directed scenarios with a pulse scoreboard for str_match
module tb_str_match;
  localparam int TO = 20;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_vld = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic cmd_vld, run;
  logic [1:0] cmd_code;
  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;
  int last_e = 0;
  int exp_run = 0;
  typedef struct {int code; int e; int r;} exp_t;
  exp_t sb [$];

  str_match #(.TIMEOUT(TO), .MAX_LEN(8)) dut (
    .clk(clk), .rst(rst), .rx_vld(rx_vld), .rx_data(rx_data),
    .cmd_vld(cmd_vld), .cmd_code(cmd_code), .run(run)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int classify(input string s);
    return (s == "start") ? 1 : (s == "stop") ? 2 : (s == "hitsz") ? 3 : 0;
  endfunction

  task automatic expect_pulse(input int code, input int e);
    exp_t x;
    exp_run = (code == 1) ? 1 : (code == 2) ? 0 : exp_run;
    x.code = code; x.e = e; x.r = exp_run;
    sb.push_back(x);
  endtask

  task automatic strobe(input logic [7:0] b, input int pre);
    repeat (pre) @(negedge clk);
    rx_vld = 1'b1;
    rx_data = b;
    last_e = cyc + 1;
    @(negedge clk);
    rx_vld = 1'b0;
  endtask

  task automatic send_word(input string s, input bit term);
    for (int i = 0; i < s.len(); i++) strobe(s[i], 4);
    if (term) begin
      strobe(8'h0D, 4);
      expect_pulse(classify(s), last_e + 1);
    end else expect_pulse(classify(s), last_e + TO + 1);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    repeat (TO + 5) @(negedge clk);
    chk(tag, sb.size(), 0);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (!rst && cmd_vld) begin
          exp_t x;
          chk("pulse_expected", int'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            x = sb.pop_front();
            chk("cmd_code", int'(cmd_code), x.code);
            chk("pulse_cycle", cyc, x.e);
            chk("run_at_pulse", int'(run), x.r);
          end
        end
      end
    join_none
    #2;
    chk("rst_cmd_vld", int'(cmd_vld), 0);
    chk("rst_cmd_code", int'(cmd_code), 0);
    chk("rst_run", int'(run), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send_word("start", 1'b0);
    drain("s1_drain");
    chk("s1_run", int'(run), 1);
    send_word("stop", 1'b1);
    drain("s2_drain");
    chk("s2_run", int'(run), 0);
    send_word("hitsz", 1'b0);
    repeat (40) @(negedge clk);
    send_word("abc", 1'b0);
    drain("s3_drain");
    chk("s3_run", int'(run), 0);
    send_word("startstop", 1'b0);
    drain("s4_long");
    send_word("Start", 1'b0);
    drain("s4_upper");
    strobe(8'h0D, 4);
    strobe(8'h0A, 4);
    drain("s4_crlf");
    strobe("s", 4);
    strobe("t", 4);
    strobe("o", 4);
    strobe("p", 19);
    expect_pulse(2, last_e + TO + 1);
    drain("s5_drain");
    send_word("start", 1'b1);
    drain("s6_pre");
    chk("s6_run_pre", int'(run), 1);
    strobe("s", 4);
    strobe("t", 4);
    strobe("a", 4);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("s6_async_cmd_vld", int'(cmd_vld), 0);
    chk("s6_async_cmd_code", int'(cmd_code), 0);
    chk("s6_async_run", int'(run), 0);
    exp_run = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * TO) @(negedge clk);
    chk("s6_no_partial", sb.size(), 0);
    send_word("start", 1'b0);
    drain("s6_drain");
    chk("s6_run", int'(run), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
